// File: rtl/shift_add_mul4.sv
// 4x4 unsigned shift-and-add multiplier that borrows an external 4-bit adder.
// One operand pair is accepted from IDLE; four CALC steps follow, then a DONE pulse.
module shift_add_mul4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [3:0] add_sum,
  input  logic       add_cout,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [1:0] dbg_state
);

  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // start while busy=1 is dropped. done is a single-cycle valid for product,
  // which then holds until the next completed multiply (no ready, no stall).

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [3:0] m_reg, m_nx;
  logic [3:0] q_reg, q_nx;
  logic [3:0] a_reg, a_nx;
  logic [7:0] product_r, product_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      m_reg     <= 4'h0;
      q_reg     <= 4'h0;
      a_reg     <= 4'h0;
      product_r <= 8'h00;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      m_reg     <= m_nx;
      q_reg     <= q_nx;
      a_reg     <= a_nx;
      product_r <= product_nx;
    end
  end

  // The carry register above A is cleared by every shift, so it only ever
  // holds 0 and appears here as the zero shifted into nothing.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    m_nx       = m_reg;
    q_nx       = q_reg;
    a_nx       = a_reg;
    product_nx = product_r;
    case (state)
      IDLE: begin
        if (start) begin
          m_nx     = multiplicand;
          q_nx     = multiplier;
          a_nx     = 4'h0;
          cnt_nx   = 2'd0;
          state_nx = CALC;
        end
      end
      CALC: begin
        a_nx   = {add_cout, add_sum[3:1]};
        q_nx   = {add_sum[0], q_reg[3:1]};
        cnt_nx = cnt + 2'd1;
        if (cnt == 2'd3) begin
          product_nx = {add_cout, add_sum, q_reg[3:1]};
          state_nx   = DONE_ST;
        end
      end
      DONE_ST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign add_a     = a_reg;
  assign add_b     = q_reg[0] ? m_reg : 4'h0;
  assign add_cin   = 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE_ST);
  assign product   = product_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_add_mul4.sv
// Bench for shift_add_mul4: gate-level ripple adder on the adder port, a
// cycle-count model with a product scoreboard, and directed vectors.
module tb_shift_add_mul4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] multiplicand, multiplier;
  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       busy, done;
  logic [7:0] product;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  shift_add_mul4 dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .product(product), .dbg_state(dbg_state)
  );

  // Structural 4-bit ripple-carry adder built from full-adder equations.
  logic c1, c2, c3;
  assign add_sum[0] = add_a[0] ^ add_b[0] ^ add_cin;
  assign c1         = (add_a[0] & add_b[0]) | ((add_a[0] ^ add_b[0]) & add_cin);
  assign add_sum[1] = add_a[1] ^ add_b[1] ^ c1;
  assign c2         = (add_a[1] & add_b[1]) | ((add_a[1] ^ add_b[1]) & c1);
  assign add_sum[2] = add_a[2] ^ add_b[2] ^ c2;
  assign c3         = (add_a[2] & add_b[2]) | ((add_a[2] ^ add_b[2]) & c2);
  assign add_sum[3] = add_a[3] ^ add_b[3] ^ c3;
  assign add_cout   = (add_a[3] & add_b[3]) | ((add_a[3] ^ add_b[3]) & c3);

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Model: phase 0 idle, 1..4 the four steps, 5 the done cycle.
  int         phase = 0;
  logic [7:0] exp_prod = 8'h00;
  logic [7:0] pend = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 0;
      exp_prod <= 8'h00;
      exp_q.delete();
    end else if (phase == 0) begin
      if (start) begin
        pend  <= 8'(multiplicand) * 8'(multiplier);
        exp_q.push_back(8'(multiplicand) * 8'(multiplier));
        phase <= 1;
      end
    end else if (phase == 4) begin
      exp_prod <= pend;
      phase    <= 5;
    end else if (phase == 5) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", 8'(busy), 8'(phase != 0));
      chk("model_done", 8'(done), 8'(phase == 5));
      chk("model_product", product, exp_prod);
      chk("add_cin", 8'(add_cin), 8'h00);
      if (done === 1'b1) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_done actual=1 expected=0 at t=%0t", $time);
        end else begin
          chk("sb_product", product, exp_q.pop_front());
        end
      end
    end
  end

  // Steps edges until done is seen (at most 30), returning the edge count.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 at t=%0t", $time);
    end
  endtask

  task automatic do_op(input string name, input logic [3:0] m, input logic [3:0] q,
                       input logic [7:0] exp);
    int cyc;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = ~q;
    wait_done(cyc);
    chk({name, "_latency"}, 8'(cyc), 8'd4);
    chk({name, "_product"}, product, exp);
    @(posedge clk); #1;
    chk({name, "_idle"}, 8'(busy), 8'h00);
  endtask

  initial begin
    int cyc;
    int last_done;
    int seen0;
    logic [3:0] mm, qq;
    rst = 1'b0;
    start = 1'b0;
    multiplicand = 4'h0;
    multiplier = 4'h0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_done", 8'(done), 8'h00);
    chk("rst_product", product, 8'h00);
    chk("rst_add_a", 8'(add_a), 8'h00);
    chk("rst_add_b", 8'(add_b), 8'h00);
    chk("rst_add_cin", 8'(add_cin), 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_op("m15q15", 4'd15, 4'd15, 8'hE1);
    repeat (3) @(posedge clk);
    #1 chk("product_hold", product, 8'hE1);
    do_op("m13q11", 4'd13, 4'd11, 8'h8F);
    do_op("m0q9", 4'd0, 4'd9, 8'h00);
    do_op("m9q1", 4'd9, 4'd1, 8'h09);

    // start raised again while busy must be ignored.
    seen0 = done_seen;
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start        = 1'b1;
    @(posedge clk); #1;
    multiplicand = 4'd15;
    multiplier   = 4'd15;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    chk("busy_start_product", product, 8'h0F);
    repeat (8) @(posedge clk);
    #1 chk("busy_start_single_done", 8'(done_seen - seen0), 8'd1);

    // Reset in the third step aborts with no done pulse.
    multiplicand = 4'd5;
    multiplier   = 4'd6;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    seen0 = done_seen;
    rst = 1'b1;
    #1;
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_product", product, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("abort_no_done", 8'(done_seen - seen0), 8'd0);
    do_op("m2q7", 4'd2, 4'd7, 8'h0E);

    // Sweep with start held high: every pair, back to back.
    multiplicand = 4'd0;
    multiplier   = 4'd0;
    start        = 1'b1;
    last_done    = 0;
    for (int k = 0; k < 256; k++) begin
      mm = 4'(k >> 4);
      qq = 4'(k);
      multiplicand = mm;
      multiplier   = qq;
      @(posedge clk); #1;
      wait_done(cyc);
      chk("sweep_product", product, 8'(mm) * 8'(qq));
      if (k > 0) chk("sweep_spacing", 8'(cycle - last_done), 8'd6);
      last_done = cycle;
      if (k == 255) start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1 chk("sweep_end_idle", 8'(busy), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mul4.md
SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  4  operand M, unsigned; captured at accepted start.
REQ-006 multiplier  input  4  operand Q, unsigned; captured at accepted start.
REQ-007 add_a  output  4  A operand to the external 4-bit ripple-carry adder.
REQ-008 add_b  output  4  B operand to the external adder.
REQ-009 add_cin  output  1  carry-in to the external adder; constant 0.
REQ-010 add_sum  input  4  sum returned combinationally by the external adder.
REQ-011 add_cout  input  1  carry-out returned by the external adder.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse; product valid.
REQ-014 product  output  8  registered unsigned result M*Q.

Function
REQ-015 The FSM SHALL have the states IDLE, CALC and DONE, plus a 2-bit iteration counter cnt.
REQ-016 In IDLE with start=1 at an edge: load Mreg=multiplicand, Qreg=multiplier, Areg=0, Creg=0, cnt=0; go to CALC.
REQ-017 In IDLE with start=0: hold all state.
REQ-018 The adder drive SHALL be combinational: add_a=Areg; add_b=Qreg[0] ? Mreg : 4'h0; add_cin=0.
REQ-019 Each CALC edge SHALL perform {Creg,Areg,Qreg} <= {0, add_cout, add_sum, Qreg} >> 1, i.e. Creg=0, Areg={add_cout, add_sum[3:1]}, Qreg={add_sum[0], Qreg[3:1]}.
REQ-020 Each CALC edge SHALL increment cnt; at the edge where cnt==3, product SHALL load the post-shift {Areg,Qreg} and state SHALL go to DONE.
REQ-021 In DONE: done=1 for exactly that cycle; the next edge SHALL return to IDLE; done=0 in all other states.
REQ-022 Latency: done is high in the cycle following the 5th rising edge, counting the edge that accepted start as the 1st.
REQ-023 product SHALL hold its value from DONE until it is overwritten by the next completed multiply.
REQ-024 start asserted while busy=1 SHALL be ignored, with no effect on operands, counter or result.
REQ-025 start held high continuously SHALL be accepted in IDLE after DONE, giving back-to-back operations of 6 cycles each.
REQ-026 Operand inputs may change freely after an accepted start; the result SHALL depend only on the captured values.
REQ-027 The result SHALL be exact for all 256 operand pairs, with no overflow; the maximum is 15*15=225.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, cnt=0, Mreg=Qreg=Areg=0, Creg=0, product=8'h00, done=0, busy=0.
REQ-029 The add_* outputs SHALL follow combinationally from the reset register values (add_a=0, add_b=0, add_cin=0).
REQ-030 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; product SHALL read 0.
REQ-031 After rst deasserts, the first start accepted SHALL behave exactly as in REQ-016.

Verification
REQ-032 M=15, Q=15, start pulsed 1 cycle -> busy for 5 cycles, done pulse, product=8'hE1 (225).
REQ-033 M=13, Q=11 -> product=8'h8F (143); M=0, Q=9 -> product=8'h00; M=9, Q=1 -> product=8'h09.
REQ-034 Start M=3, Q=5; during CALC assert start with M=15, Q=15 -> product=8'h0F, then return to IDLE with no second done.
REQ-035 Assert rst in the 3rd CALC cycle -> busy=0, product=0 and no done; then start M=2, Q=7 -> product=8'h0E.
REQ-036 Exhaustive sweep of all 256 (M,Q) pairs with start held high -> every done pulse carries M*Q, and done pulses are spaced 6 cycles apart.
REQ-037 The bench SHALL instantiate the real 4-bit ripple-carry adder on add_a, add_b, add_cin, add_sum and add_cout, not a behavioural model.
